// File: rtl/sync_counter_16b_if.sv
// Control and data bundle for the 16-bit cascaded counter.
// The master drives the enable, mode and load value; the slave drives the count and the carry chain.
interface sync_counter_16b_if;
  logic        ENB;
  logic [1:0]  MODO;
  logic [15:0] D;
  logic [15:0] Q;
  logic        w1;
  logic        w2;
  logic        w3;
  logic        RCO;

  modport master (
    output ENB, MODO, D,
    input  Q, w1, w2, w3, RCO
  );

  modport slave (
    input  ENB, MODO, D,
    output Q, w1, w2, w3, RCO
  );
endinterface

// File: rtl/sync_counter_16b.sv
// 16-bit up/down-1/down-3/load counter built from four chained 4-bit slices.
// One-cycle latency; ENB=0 holds the count; the carry/borrow outputs describe the pending edge.
module sync_counter_16b (
  input  logic               CLK,
  input  logic               RESET,
  sync_counter_16b_if.slave  bus
);

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DN1  = 2'b01;
  localparam logic [1:0] MODE_DN3  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  logic [15:0] q_q;
  logic [15:0] q_d;
  logic [4:0]  chain;
  logic        count_en;
  logic        mode_up;

  // The carry chain only exists while a counting operation is pending.
  assign count_en = bus.ENB & ~RESET & (bus.MODO != MODE_LOAD);
  assign mode_up  = (bus.MODO == MODE_UP);
  assign chain[0] = count_en;

  for (genvar g = 0; g < 4; g++) begin : g_slice
    logic [3:0] nib;
    logic [3:0] step;
    logic [3:0] nib_next;
    logic       wrap;

    assign nib = q_q[4*g +: 4];

    // Only the lowest slice subtracts 3; upper slices just absorb a borrow of 1.
    assign step = ((g == 0) && (bus.MODO == MODE_DN3)) ? 4'd3 : 4'd1;

    assign wrap     = mode_up ? (nib == 4'hF) : (nib < step);
    assign nib_next = mode_up ? (nib + step) : (nib - step);

    assign chain[g+1] = chain[g] & wrap;

    assign q_d[4*g +: 4] = !bus.ENB                 ? nib :
                           (bus.MODO == MODE_LOAD)  ? bus.D[4*g +: 4] :
                           chain[g]                 ? nib_next :
                                                      nib;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      q_q <= 16'h0000;
    end else begin
      q_q <= q_d;
    end
  end

  assign bus.Q   = q_q;
  assign bus.w1  = chain[1];
  assign bus.w2  = chain[2];
  assign bus.w3  = chain[3];
  assign bus.RCO = chain[4];

endmodule

// File: tb/tb_sync_counter_16b.sv
// Randomized and directed bench for sync_counter_16b against a plain-arithmetic reference model.
module tb_sync_counter_16b;

  logic CLK = 1'b0;
  logic RESET;

  always #5 CLK = ~CLK;

  sync_counter_16b_if bus ();

  sync_counter_16b dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_q;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_car(input logic [15:0] q, input logic rst,
                                           input logic enb, input logic [1:0] modo);
    if (rst || !enb) return 4'b0000;
    case (modo)
      2'b00:   return {q == 16'hFFFF, q[11:0] == 12'hFFF, q[7:0] == 8'hFF, q[3:0] == 4'hF};
      2'b01:   return {q == 16'h0000, q[11:0] == 12'h000, q[7:0] == 8'h00, q[3:0] == 4'h0};
      2'b10:   return {q < 16'd3, q[11:0] < 12'd3, q[7:0] < 8'd3, q[3:0] < 4'd3};
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [15:0] model_next(input logic [15:0] q, input logic rst,
                                             input logic enb, input logic [1:0] modo,
                                             input logic [15:0] d);
    if (rst) return 16'h0000;
    if (!enb) return q;
    case (modo)
      2'b00:   return q + 16'd1;
      2'b01:   return q - 16'd1;
      2'b10:   return q - 16'd3;
      default: return d;
    endcase
  endfunction

  function automatic logic [15:0] dut_car();
    return {12'h000, bus.RCO, bus.w3, bus.w2, bus.w1};
  endfunction

  task automatic drive(input logic rst, input logic enb, input logic [1:0] modo,
                       input logic [15:0] d);
    RESET    = rst;
    bus.ENB  = enb;
    bus.MODO = modo;
    bus.D    = d;
  endtask

  // Check the pending carries, take one edge, then check the registered count.
  task automatic tick(input string tag);
    #1;
    chk({tag, "_car"}, dut_car(), {12'h000, model_car(exp_q, RESET, bus.ENB, bus.MODO)});
    @(posedge CLK);
    exp_q = model_next(exp_q, RESET, bus.ENB, bus.MODO, bus.D);
    #1;
    chk({tag, "_q"}, bus.Q, exp_q);
  endtask

  task automatic load(input logic [15:0] v);
    drive(1'b0, 1'b1, 2'b11, v);
    tick("load");
  endtask

  initial begin
    exp_q = 16'h0000;

    // Reset with counting requested, then count up three times.
    drive(1'b1, 1'b1, 2'b00, 16'h0000);
    tick("rst0");
    tick("rst1");
    chk("rst_q", bus.Q, 16'h0000);
    chk("rst_car", dut_car(), 16'h0000);
    drive(1'b0, 1'b1, 2'b00, 16'h0000);
    repeat (3) tick("up3");
    chk("up3_q", bus.Q, 16'h0003);

    // Up through the 16-bit wrap.
    load(16'hFFFD);
    chk("ld_fffd", bus.Q, 16'hFFFD);
    drive(1'b0, 1'b1, 2'b00, 16'h0000);
    tick("wrap_a");
    tick("wrap_b");
    #1 chk("ffff_car", dut_car(), 16'h000F);
    tick("wrap_c");
    chk("wrap_q", bus.Q, 16'h0000);

    load(16'h00EF);
    drive(1'b0, 1'b1, 2'b00, 16'h0000);
    #1 chk("ef_car", dut_car(), 16'h0001);
    tick("ef_up");
    load(16'h0FFF);
    drive(1'b0, 1'b1, 2'b00, 16'h0000);
    #1 chk("fff_car", dut_car(), 16'h0007);
    tick("fff_up");

    // Down-1 across a byte boundary and through zero.
    load(16'h0100);
    drive(1'b0, 1'b1, 2'b01, 16'h0000);
    #1 chk("dn1_100_car", dut_car(), 16'h0003);
    tick("dn1_100");
    chk("dn1_100_q", bus.Q, 16'h00FF);
    load(16'h0000);
    drive(1'b0, 1'b1, 2'b01, 16'h0000);
    #1 chk("dn1_0_car", dut_car(), 16'h000F);
    tick("dn1_0");
    chk("dn1_0_q", bus.Q, 16'hFFFF);

    // Down-3 near zero.
    load(16'h0005);
    drive(1'b0, 1'b1, 2'b10, 16'h0000);
    #1 chk("dn3_5_car", dut_car(), 16'h0000);
    tick("dn3_5");
    chk("dn3_5_q", bus.Q, 16'h0002);
    #1 chk("dn3_2_car", dut_car(), 16'h000F);
    tick("dn3_2");
    chk("dn3_2_q", bus.Q, 16'hFFFF);
    load(16'h0001);
    drive(1'b0, 1'b1, 2'b10, 16'h0000);
    tick("dn3_1");
    chk("dn3_1_q", bus.Q, 16'hFFFE);

    // Hold with ENB low while mode and data wander.
    load(16'h1234);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 2'($urandom_range(0, 3)), 16'($urandom));
      tick("hold");
    end
    chk("hold_q", bus.Q, 16'h1234);

    // Reset in the middle of counting, then resume from zero.
    load(16'h00F0);
    drive(1'b0, 1'b1, 2'b00, 16'h0000);
    tick("mid_up");
    drive(1'b1, 1'b1, 2'b00, 16'h0000);
    tick("mid_rst");
    chk("mid_rst_q", bus.Q, 16'h0000);
    drive(1'b0, 1'b1, 2'b00, 16'h0000);
    tick("mid_rel");
    chk("mid_rel_q", bus.Q, 16'h0001);

    // Random mix, with load values biased toward the wrap boundaries.
    for (int i = 0; i < 500; i++) begin
      logic [15:0] d;
      case ($urandom_range(0, 3))
        0:       d = 16'($urandom_range(0, 4));
        1:       d = 16'hFFFF - 16'($urandom_range(0, 4));
        2:       d = {4'($urandom), 12'hFFF};
        default: d = 16'($urandom);
      endcase
      drive($urandom_range(0, 19) == 0, $urandom_range(0, 4) != 0,
            2'($urandom_range(0, 3)), d);
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_counter_16b.md
Name: sync_counter_16b

Overview:
- 16-bit synchronous counter built from four cascaded 4-bit counter slices.
- Modes: count up by 1, count down by 1, count down by 3, parallel load.
- Exposes the three inter-slice carry/borrow signals (w1, w2, w3) and a final ripple-carry-out (RCO), so a bench can check slice chaining alongside a standalone 4-bit slice.

Parameters:
- None. Width is fixed at 16 bits as 4 slices of 4 bits.

Ports:
- CLK    input   1   Clock; all state changes on rising edge.
- RESET  input   1   Synchronous, active-high reset.
- ENB    input   1   Count/load enable; when 0, Q holds.
- MODO   input   2   Operation select: 00 up+1, 01 down-1, 10 down-3, 11 load D.
- D      input   16  Parallel load value, used when MODO=11.
- Q      output  16  Registered counter value.
- w1     output  1   Carry/borrow out of slice 0 (bits 3:0) into slice 1.
- w2     output  1   Carry/borrow out of bits 7:0 into slice 2.
- w3     output  1   Carry/borrow out of bits 11:0 into slice 3.
- RCO    output  1   Carry/borrow out of bit 15 (whole-counter wrap).

Behaviour:
Priority and update:
- Priority at each rising CLK edge: RESET > ENB=0 (hold) > MODO operation.
- RESET=1: Q <= 16'h0000 on that edge, regardless of ENB, MODO or D.
- ENB=0, RESET=0: Q holds.
- ENB=1, MODO=00: Q <= Q+1 mod 2^16.
- ENB=1, MODO=01: Q <= Q-1 mod 2^16.
- ENB=1, MODO=10: Q <= Q-3 mod 2^16.
- ENB=1, MODO=11: Q <= D.
- Latency is one cycle: the new Q is visible after the edge; no pipeline.

Carry/borrow outputs (combinational from current Q, MODO, ENB; describe the pending transition):
- Up (00): w1 = (Q[3:0]==4'hF); w2 = (Q[7:0]==8'hFF); w3 = (Q[11:0]==12'hFFF); RCO = (Q==16'hFFFF).
- Down-1 (01): w1 = (Q[3:0]==0); w2 = (Q[7:0]==0); w3 = (Q[11:0]==0); RCO = (Q==0).
- Down-3 (10): w1 = (Q[3:0]<3); w2 = (Q[7:0]<3); w3 = (Q[11:0]<3); RCO = (Q<3).
- Load (11), ENB=0, or RESET=1: w1=w2=w3=RCO=0.
- Invariants: RCO implies w3, w3 implies w2, w2 implies w1.

Implementation:
- Four identical 4-bit slices.
- Each slice updates its nibble only when the lower carry/borrow chain permits; for down-3, slice 0 subtracts 3 and higher slices subtract 1 on borrow.
- Result must equal the 16-bit arithmetic above.

Boundary conditions:
- Wrap-around: 0xFFFF up -> 0x0000 (RCO=1 in the cycle before the edge); 0x0000 down-1 -> 0xFFFF; 0x0001 down-3 -> 0xFFFE; 0x0002 down-3 -> 0xFFFF.
- MODO or D changing mid-run: takes effect at the next edge; no internal mode state.
- RESET asserted mid-count: Q is 0 after that edge; counting resumes from 0 on the first edge with RESET=0.
- Power-up Q is undefined until the first reset edge; the bench must reset first.

Test Plan:
1. RESET=1 for 2 edges with ENB=1, MODO=00 -> Q=0x0000, w1..w3=RCO=0 after reset; deassert, 3 edges -> Q=0x0003.
2. Load then count up: MODO=11, D=0xFFFD, ENB=1, 1 edge -> Q=0xFFFD. Then MODO=00:
   - Q=0xFFFD -> 0xFFFE -> 0xFFFF -> 0x0000.
   - w1,w2,w3,RCO all 1 only while Q=0xFFFF.
   - Intermediate: load 0x00EF -> w1=1, w2=0; load 0x0FFF -> w3=1, RCO=0.
3. Down-1: load 0x0100, MODO=01 -> w1=w2=1, w3=0 before the edge; Q=0x00FF after. From Q=0x0000 -> RCO=1, Q=0xFFFF.
4. Down-3: load 0x0005, MODO=10 -> Q=0x0002 (w1=0 before). Next edge -> Q=0xFFFF with w1=w2=w3=RCO=1 before the edge.
5. Hold: Q=0x1234, ENB=0, any MODO/D for 4 edges -> Q stays 0x1234, all carries 0.
6. Reset mid-operation: counting up at Q=0x00F0, assert RESET for 1 edge with ENB=1 -> Q=0x0000. Release -> Q=0x0001 next edge.
